store_buffer: RTL and testbench
===============================

// Module: store_buffer
// PURPOSE
//  Posted-write FIFO between the EX/MEM pipeline boundary and data_memory.
//  Accepts stores from the pipeline and drains them in order into the data memory write port.
//  Drains only when that port is idle, and never in a cycle when a load owns it (mem_busy=1).
//  Forwards buffered store data to same-address loads, so loads never see stale memory.
// PARAMETERS
//  DEPTH   4   number of entries; power of two, >= 2
//  ADDR_W  64  address width; matches the data_memory address port
//  DATA_W  32  data width; matches data_memory write_data/read_data
// PORTS
//  clk             in   1       rising-edge clock, shared with data_memory
//  rst_n           in   1       asynchronous, active-low reset
//  st_valid        in   1       pipeline presents a store this cycle
//  st_ready        out  1       buffer can accept a store (= !full)
//  st_addr         in   ADDR_W  store address
//  st_data         in   DATA_W  store data
//  ld_addr         in   ADDR_W  address of the load currently in MEM stage
//  ld_hit          out  1       some valid entry matches ld_addr exactly
//  ld_data         out  DATA_W  data of youngest matching entry; 0 when !ld_hit
//  mem_busy        in   1       load is using the data_memory port this cycle
//  mem_write       out  1       write strobe to data_memory.mem_write
//  mem_address     out  ADDR_W  to data_memory.address during drain
//  mem_write_data  out  DATA_W  to data_memory.write_data
//  count           out  clog2(DEPTH)+1  valid entries
//  empty / full    out  1       count==0 / count==DEPTH
// BEHAVIOUR
//  Reset (async, rst_n=0):
//   - head=tail=count=0; all entries invalid.
//   - Outputs: st_ready=1, empty=1, full=0, mem_write=0, ld_hit=0, ld_data=0.
//   - Pending stores are discarded, including any mid-drain.
//  Push:
//   - st_valid && st_ready at a rising edge writes {st_addr, st_data} at tail; tail+1 mod DEPTH.
//   - st_valid while full is ignored; upstream stalls on st_ready=0.
//  Drain (combinational strobe):
//   - mem_write = !empty && !mem_busy.
//   - mem_address/mem_write_data = head entry whenever !empty, else 0.
//   - data_memory commits on the same rising edge.
//   - At that edge the head entry is invalidated and head+1 mod DEPTH.
//   - Latency: a store pushed at edge N is written to memory at edge N+1 at the earliest.
//  Simultaneous push+pop in one edge:
//   - count unchanged; both pointers advance.
//   - Not reachable when full, because st_ready=0.
//  Forwarding:
//   - Combinational compare of ld_addr against every valid entry, full ADDR_W equality.
//   - Youngest matching entry (closest to tail) wins.
//   - The head entry being drained this cycle still counts as valid for forwarding.
//   - A store pushed in the same cycle is not visible until the next cycle.
//  Ordering:
//   - Strict FIFO; no write merging; duplicate addresses each drain separately.
//  Pointers:
//   - clog2(DEPTH) bits each, with natural wrap.
//   - full/empty come from the count register, not from pointer compare.
// TESTING
//  T1 reset: rst_n=0 -> st_ready=1, empty=1, mem_write=0, count=0.
//  T2 fill+stall: mem_busy=1; push A=8/D=1, A=16/D=2, A=24/D=3, A=32/D=4.
//     -> full=1, st_ready=0; a 5th push is dropped, count=4.
//  T3 drain order: then mem_busy=0 for 4 cycles.
//     -> mem_write=1 with addresses 8,16,24,32 in order; empty=1 after edge 4.
//     -> data_memory read of 24 returns 3.
//  T4 forwarding: mem_busy=1; push A=6/D=100, then A=6/D=200; ld_addr=6.
//     -> ld_hit=1, ld_data=200.
//     -> ld_addr=7 gives ld_hit=0, ld_data=0.
//  T5 push+pop and wrap: count=2, mem_busy=0, push every cycle for 6 cycles.
//     -> count stays 2 throughout, pointers wrap past DEPTH-1.
//     -> memory contents match the push order.
//  T6 reset mid-drain: count=3, assert rst_n=0 between edges.
//     -> mem_write drops to 0 immediately; after release, empty=1 and no further writes.

Source files
------------

// File: rtl/store_buffer_if.sv
// Handshake and memory-port bundle for the posted-write store buffer.
// The slave modport is the buffer's view; the master modport is the pipeline/memory side.
interface store_buffer_if #(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 64,
    parameter int DATA_W = 32
);
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic              st_valid;
    logic              st_ready;
    logic [ADDR_W-1:0] st_addr;
    logic [DATA_W-1:0] st_data;
    logic [ADDR_W-1:0] ld_addr;
    logic              ld_hit;
    logic [DATA_W-1:0] ld_data;
    logic              mem_busy;
    logic              mem_write;
    logic [ADDR_W-1:0] mem_address;
    logic [DATA_W-1:0] mem_write_data;
    logic [CNT_W-1:0]  count;
    logic              empty;
    logic              full;

    modport slave (
        input  st_valid, st_addr, st_data, ld_addr, mem_busy,
        output st_ready, ld_hit, ld_data, mem_write, mem_address, mem_write_data,
               count, empty, full
    );

    modport master (
        output st_valid, st_addr, st_data, ld_addr, mem_busy,
        input  st_ready, ld_hit, ld_data, mem_write, mem_address, mem_write_data,
               count, empty, full
    );
endinterface

// File: rtl/store_buffer.sv
// Posted-write FIFO between EX/MEM and data_memory: drains in order when the
// memory port is free and forwards the youngest matching store to loads.
module store_buffer #(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 64,
    parameter int DATA_W = 32
) (
    input  logic          clk,
    input  logic          rst_n,
    store_buffer_if.slave sb
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [ADDR_W-1:0] addr_q [DEPTH];
    logic [DATA_W-1:0] data_q [DEPTH];
    logic [DEPTH-1:0]  valid_q, valid_d;
    logic [PTR_W-1:0]  head_q, head_d;
    logic [PTR_W-1:0]  tail_q, tail_d;
    logic [CNT_W-1:0]  count_q, count_d;

    logic              full, empty, push, pop;
    logic              hit;
    logic [DATA_W-1:0] fwd_data;
    logic [PTR_W-1:0]  idx;

    assign full  = (count_q == CNT_W'(DEPTH));
    assign empty = (count_q == '0);
    assign push  = sb.st_valid && !full;
    assign pop   = !empty && !sb.mem_busy;

    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        valid_d = valid_q;
        if (pop) begin
            head_d          = head_q + PTR_W'(1);
            valid_d[head_q] = 1'b0;
        end
        if (push) begin
            tail_d          = tail_q + PTR_W'(1);
            valid_d[tail_q] = 1'b1;
        end
        case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            valid_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            valid_q <= valid_d;
        end
    end

    // Payload storage carries no reset; the valid bits alone decide visibility.
    always_ff @(posedge clk) begin
        if (push) begin
            addr_q[tail_q] <= sb.st_addr;
            data_q[tail_q] <= sb.st_data;
        end
    end

    // Walk from oldest to youngest so the last match is the youngest store.
    always_comb begin
        hit      = 1'b0;
        fwd_data = '0;
        idx      = head_q;
        for (int i = 0; i < DEPTH; i++) begin
            idx = head_q + PTR_W'(i);
            if (valid_q[idx] && (addr_q[idx] == sb.ld_addr)) begin
                hit      = 1'b1;
                fwd_data = data_q[idx];
            end
        end
    end

    assign sb.st_ready       = !full;
    assign sb.full           = full;
    assign sb.empty          = empty;
    assign sb.count          = count_q;
    assign sb.mem_write      = pop;
    assign sb.mem_address    = empty ? '0 : addr_q[head_q];
    assign sb.mem_write_data = empty ? '0 : data_q[head_q];
    assign sb.ld_hit         = hit;
    assign sb.ld_data        = fwd_data;
endmodule

// File: tb/tb_store_buffer.sv
// Directed bench for store_buffer: a vector table for fill/drain/forward/wrap,
// plus a hand sequence for reset during drain, against a small data_memory model.
module tb_store_buffer;
    localparam int DEPTH  = 4;
    localparam int ADDR_W = 64;
    localparam int DATA_W = 32;
    localparam int NVEC   = 23;

    logic clk;
    logic rst_n;
    int   total;
    int   bad;
    int   wr_cnt;
    logic [DATA_W-1:0] mem [0:255];

    store_buffer_if #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) sb ();

    store_buffer #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .sb    (sb.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural data_memory: commits on the same edge as the strobe.
    always @(posedge clk) begin
        if (sb.mem_write) begin
            mem[sb.mem_address[7:0]] <= sb.mem_write_data;
            wr_cnt = wr_cnt + 1;
        end
    end

    typedef struct {
        logic        v;
        logic [63:0] a;
        logic [31:0] d;
        logic [63:0] ld;
        logic        busy;
        logic [2:0]  cnt;
        logic        full;
        logic        empty;
        logic        rdy;
        logic        mw;
        logic [63:0] maddr;
        logic [31:0] mdata;
        logic        hit;
        logic [31:0] ldd;
    } vec_t;

    vec_t tbl [NVEC];

    function automatic vec_t mk(logic v, logic [63:0] a, logic [31:0] d, logic [63:0] ld,
                                logic busy, logic [2:0] cnt, logic full, logic empty,
                                logic rdy, logic mw, logic [63:0] maddr, logic [31:0] mdata,
                                logic hit, logic [31:0] ldd);
        vec_t r;
        r.v = v; r.a = a; r.d = d; r.ld = ld; r.busy = busy;
        r.cnt = cnt; r.full = full; r.empty = empty; r.rdy = rdy; r.mw = mw;
        r.maddr = maddr; r.mdata = mdata; r.hit = hit; r.ldd = ldd;
        return r;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total = total + 1;
        if (act !== exp) begin
            bad = bad + 1;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [63:0] a, input logic [31:0] d,
                         input logic [63:0] ld, input logic busy);
        sb.st_valid = v;
        sb.st_addr  = a;
        sb.st_data  = d;
        sb.ld_addr  = ld;
        sb.mem_busy = busy;
    endtask

    initial begin
        total  = 0;
        bad    = 0;
        wr_cnt = 0;
        for (int i = 0; i < 256; i++) mem[i] = '0;

        // fill+stall (5th push dropped), drain order, forwarding, push+pop with wrap
        tbl[0]  = mk(1,  8,   1,  0, 1, 0, 0, 1, 1, 0,  0,   0, 0,   0);
        tbl[1]  = mk(1, 16,   2,  8, 1, 1, 0, 0, 1, 0,  8,   1, 1,   1);
        tbl[2]  = mk(1, 24,   3, 16, 1, 2, 0, 0, 1, 0,  8,   1, 1,   2);
        tbl[3]  = mk(1, 32,   4, 24, 1, 3, 0, 0, 1, 0,  8,   1, 1,   3);
        tbl[4]  = mk(1, 40,   5, 40, 1, 4, 1, 0, 0, 0,  8,   1, 0,   0);
        tbl[5]  = mk(0,  0,   0, 32, 0, 4, 1, 0, 0, 1,  8,   1, 1,   4);
        tbl[6]  = mk(0,  0,   0,  8, 0, 3, 0, 0, 1, 1, 16,   2, 0,   0);
        tbl[7]  = mk(0,  0,   0,  0, 0, 2, 0, 0, 1, 1, 24,   3, 0,   0);
        tbl[8]  = mk(0,  0,   0,  0, 0, 1, 0, 0, 1, 1, 32,   4, 0,   0);
        tbl[9]  = mk(0,  0,   0, 40, 0, 0, 0, 1, 1, 0,  0,   0, 0,   0);
        tbl[10] = mk(1,  6, 100,  6, 1, 0, 0, 1, 1, 0,  0,   0, 0,   0);
        tbl[11] = mk(1,  6, 200,  6, 1, 1, 0, 0, 1, 0,  6, 100, 1, 100);
        tbl[12] = mk(0,  0,   0,  6, 1, 2, 0, 0, 1, 0,  6, 100, 1, 200);
        tbl[13] = mk(0,  0,   0,  7, 1, 2, 0, 0, 1, 0,  6, 100, 0,   0);
        tbl[14] = mk(1, 48,  10,  6, 0, 2, 0, 0, 1, 1,  6, 100, 1, 200);
        tbl[15] = mk(1, 56,  11,  6, 0, 2, 0, 0, 1, 1,  6, 200, 1, 200);
        tbl[16] = mk(1, 64,  12, 48, 0, 2, 0, 0, 1, 1, 48,  10, 1,  10);
        tbl[17] = mk(1, 72,  13,  6, 0, 2, 0, 0, 1, 1, 56,  11, 0,   0);
        tbl[18] = mk(1, 80,  14, 72, 0, 2, 0, 0, 1, 1, 64,  12, 1,  13);
        tbl[19] = mk(1, 88,  15,  0, 0, 2, 0, 0, 1, 1, 72,  13, 0,   0);
        tbl[20] = mk(0,  0,   0, 88, 0, 2, 0, 0, 1, 1, 80,  14, 1,  15);
        tbl[21] = mk(0,  0,   0, 80, 0, 1, 0, 0, 1, 1, 88,  15, 0,   0);
        tbl[22] = mk(0,  0,   0,  0, 0, 0, 0, 1, 1, 0,  0,   0, 0,   0);

        drive(0, 0, 0, 0, 1);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        chk("reset st_ready",  64'(sb.st_ready), 1);
        chk("reset empty",     64'(sb.empty), 1);
        chk("reset full",      64'(sb.full), 0);
        chk("reset mem_write", 64'(sb.mem_write), 0);
        chk("reset count",     64'(sb.count), 0);
        chk("reset ld_hit",    64'(sb.ld_hit), 0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < NVEC; i++) begin
            @(negedge clk);
            drive(tbl[i].v, tbl[i].a, tbl[i].d, tbl[i].ld, tbl[i].busy);
            #1;
            chk($sformatf("v%0d count", i),     64'(sb.count),          64'(tbl[i].cnt));
            chk($sformatf("v%0d full", i),      64'(sb.full),           64'(tbl[i].full));
            chk($sformatf("v%0d empty", i),     64'(sb.empty),          64'(tbl[i].empty));
            chk($sformatf("v%0d st_ready", i),  64'(sb.st_ready),       64'(tbl[i].rdy));
            chk($sformatf("v%0d mem_write", i), 64'(sb.mem_write),      64'(tbl[i].mw));
            chk($sformatf("v%0d mem_addr", i),  sb.mem_address,         tbl[i].maddr);
            chk($sformatf("v%0d mem_data", i),  64'(sb.mem_write_data), 64'(tbl[i].mdata));
            chk($sformatf("v%0d ld_hit", i),    64'(sb.ld_hit),         64'(tbl[i].hit));
            chk($sformatf("v%0d ld_data", i),   64'(sb.ld_data),        64'(tbl[i].ldd));
            if (i == 9) begin
                chk("mem[8]",  64'(mem[8]),  1);
                chk("mem[24]", 64'(mem[24]), 3);
                chk("mem[32]", 64'(mem[32]), 4);
                chk("mem[40] untouched", 64'(mem[40]), 0);
            end
        end

        chk("mem[6] last dup", 64'(mem[6]),  200);
        chk("mem[48]",         64'(mem[48]), 10);
        chk("mem[64]",         64'(mem[64]), 12);
        chk("mem[88]",         64'(mem[88]), 15);
        chk("write count",     64'(wr_cnt),  12);

        // Reset asserted between edges while three stores are pending.
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            drive(1, 64'(100 + 4 * k), 32'(7 + k), 0, 1);
        end
        @(negedge clk);
        drive(0, 0, 0, 100, 0);
        #1;
        chk("pre-rst count",     64'(sb.count), 3);
        chk("pre-rst mem_write", 64'(sb.mem_write), 1);
        chk("pre-rst mem_addr",  sb.mem_address, 100);
        #1;
        rst_n = 1'b0;
        #1;
        chk("mid-rst mem_write", 64'(sb.mem_write), 0);
        chk("mid-rst count",     64'(sb.count), 0);
        chk("mid-rst ld_hit",    64'(sb.ld_hit), 0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            #1;
            chk($sformatf("post-rst%0d mem_write", k), 64'(sb.mem_write), 0);
            chk($sformatf("post-rst%0d empty", k),     64'(sb.empty), 1);
        end
        chk("post-rst write count", 64'(wr_cnt), 12);
        chk("post-rst mem[100]",    64'(mem[100]), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
